sd_fifo_drain_sched: RTL and testbench

SD_FIFO_DRAIN_SCHED -- requirements
Module: sd_fifo_drain_sched

---
 rtl/sd_fifo_drain_sched_pkg.sv | 11 +
 rtl/sd_rr_pick.sv | 33 +++
 rtl/sd_fifo_drain_sched.sv | 144 ++++++++++++++
 tb/tb_sd_fifo_drain_sched.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sd_fifo_drain_sched_pkg.sv
// Shared helpers for the FIFO drain scheduler.
// Holds only index arithmetic that is reused across the scheduler; the lock
// state encoding and threshold compare live inside the top module.
package sd_fifo_drain_sched_pkg;

  // Increment an index with wrap at n (n need not be a power of two).
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sd_rr_pick.sv
// Rotating-priority picker.
// Returns the requesting index with the smallest rotation distance from start.
//   req   : request vector, one bit per channel
//   start : highest-priority index this cycle
//   index : chosen channel (0 when nothing requests)
//   valid : at least one request present
module sd_rr_pick #(
  parameter int unsigned inputs = 4,
  parameter int unsigned isz    = $clog2(inputs)
) (
  input  logic [inputs-1:0] req,
  input  logic [isz-1:0]    start,
  output logic [isz-1:0]    index,
  output logic              valid
);

  logic [isz-1:0] j;

  // Scan from farthest to nearest so the nearest requester wins the last write.
  always_comb begin
    index = '0;
    valid = 1'b0;
    j     = '0;
    for (int d = int'(inputs) - 1; d >= 0; d--) begin
      j = isz'((32'(start) + 32'(d)) % inputs);
      if (req[j]) begin
        index = j;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sd_fifo_drain_sched.sv
// FIFO drain scheduler: merges several FIFO tails into one output stream.
// Urgent channels (usage at or above hi_thresh) are preferred; a granted channel
// keeps the grant for up to max_burst words, then priority rotates past it.
//   clk, reset      : clock, asynchronous active-high reset
//   clken           : clock enable, nothing moves while low
//   c_srdy/c_drdy   : per-channel valid / accept
//   c_data/c_usage  : per-channel packed data and occupancy
//   p_srdy/p_drdy   : output valid / accept
//   p_data/p_chan   : output word and its source channel
module sd_fifo_drain_sched
  import sd_fifo_drain_sched_pkg::*;
#(
  parameter int unsigned inputs    = 4,
  parameter int unsigned width     = 8,
  parameter int unsigned usz       = 5,
  parameter int unsigned max_burst = 4,
  parameter int unsigned hi_thresh = 12,
  parameter int unsigned isz       = $clog2(inputs)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic [inputs-1:0]       c_srdy,
  output logic [inputs-1:0]       c_drdy,
  input  logic [inputs*width-1:0] c_data,
  input  logic [inputs*usz-1:0]   c_usage,
  output logic                    p_srdy,
  input  logic                    p_drdy,
  output logic [width-1:0]        p_data,
  output logic [isz-1:0]          p_chan
);

  typedef enum logic {StFree, StLocked} lock_e;

  lock_e            lock_q, lock_d;
  logic [isz-1:0]   gnt_q, gnt_d;
  logic [isz-1:0]   rr_q, rr_d;
  logic [7:0]       count_q, count_d;
  logic             p_srdy_q, p_srdy_d;
  logic [width-1:0] p_data_q, p_data_d;
  logic [isz-1:0]   p_chan_q, p_chan_d;

  logic [inputs-1:0] urgent;
  logic [isz-1:0]    urg_idx, nrm_idx, eff;
  logic              urg_valid, nrm_valid;
  logic              hold, xfer;

  always_comb begin
    urgent = '0;
    for (int n = 0; n < int'(inputs); n++) begin
      urgent[n] = c_srdy[n] & (32'(c_usage[n*usz +: usz]) >= hi_thresh);
    end
  end

  sd_rr_pick #(.inputs(inputs), .isz(isz)) u_pick_urgent (
    .req   (urgent),
    .start (rr_q),
    .index (urg_idx),
    .valid (urg_valid)
  );

  sd_rr_pick #(.inputs(inputs), .isz(isz)) u_pick_normal (
    .req   (c_srdy),
    .start (rr_q),
    .index (nrm_idx),
    .valid (nrm_valid)
  );

  // A locked channel that dropped srdy is simply not held, so the pickers
  // already choose someone else this same cycle.
  assign hold = (lock_q == StLocked) & c_srdy[gnt_q];
  assign eff  = hold ? gnt_q : (urg_valid ? urg_idx : nrm_idx);
  assign xfer = clken & ~reset & (hold | nrm_valid) & (~p_srdy_q | p_drdy);

  always_comb begin
    c_drdy = '0;
    if (xfer) c_drdy[eff] = 1'b1;
  end

  always_comb begin
    lock_d   = lock_q;
    gnt_d    = gnt_q;
    rr_d     = rr_q;
    count_d  = count_q;
    p_srdy_d = p_srdy_q;
    p_data_d = p_data_q;
    p_chan_d = p_chan_q;
    if (clken) begin
      if (xfer) begin
        p_srdy_d = 1'b1;
        p_data_d = c_data[32'(eff)*width +: width];
        p_chan_d = eff;
      end else if (p_drdy) begin
        p_srdy_d = 1'b0;
      end
      if ((lock_q == StLocked) && !c_srdy[gnt_q]) begin
        lock_d = StFree;
        rr_d   = isz'(wrap_inc(32'(gnt_q), inputs));
      end
      if (xfer) begin
        if (hold) begin
          count_d = count_q + 8'd1;
          if (32'(count_q) + 32'd1 == max_burst) begin
            lock_d = StFree;
            rr_d   = isz'(wrap_inc(32'(gnt_q), inputs));
          end
        end else begin
          lock_d  = StLocked;
          gnt_d   = eff;
          count_d = 8'd1;
          if (max_burst == 1) begin
            lock_d = StFree;
            rr_d   = isz'(wrap_inc(32'(eff), inputs));
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q   <= StFree;
      gnt_q    <= '0;
      rr_q     <= '0;
      count_q  <= '0;
      p_srdy_q <= 1'b0;
      p_data_q <= '0;
      p_chan_q <= '0;
    end else begin
      lock_q   <= lock_d;
      gnt_q    <= gnt_d;
      rr_q     <= rr_d;
      count_q  <= count_d;
      p_srdy_q <= p_srdy_d;
      p_data_q <= p_data_d;
      p_chan_q <= p_chan_d;
    end
  end

  assign p_srdy = p_srdy_q;
  assign p_data = p_data_q;
  assign p_chan = p_chan_q;

endmodule

// File: tb/tb_sd_fifo_drain_sched.sv
// Self-checking bench for sd_fifo_drain_sched with an in-bench reference model.
module tb_sd_fifo_drain_sched;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int U   = 5;
  localparam int MB  = 4;
  localparam int HI  = 12;

  logic           clk = 1'b0;
  logic           reset, clken, p_drdy;
  logic [N-1:0]   c_srdy, c_drdy;
  logic [N*W-1:0] c_data;
  logic [N*U-1:0] c_usage;
  logic           p_srdy;
  logic [W-1:0]   p_data;
  logic [1:0]     p_chan;
  logic [W-1:0]   dat   [N];
  logic [U-1:0]   use_v [N];

  always_comb begin
    for (int n = 0; n < N; n++) begin
      c_data[n*W +: W]  = dat[n];
      c_usage[n*U +: U] = use_v[n];
    end
  end

  sd_fifo_drain_sched #(
    .inputs(N), .width(W), .usz(U), .max_burst(MB), .hi_thresh(HI), .isz(2)
  ) dut (
    .clk(clk), .reset(reset), .clken(clken),
    .c_srdy(c_srdy), .c_drdy(c_drdy), .c_data(c_data), .c_usage(c_usage),
    .p_srdy(p_srdy), .p_drdy(p_drdy), .p_data(p_data), .p_chan(p_chan)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit         m_lock;
  logic [1:0] m_gnt, m_rr;
  int         m_cnt;
  bit         m_ov;
  logic [W-1:0] m_od;
  logic [1:0] m_oc;

  int total = 0;
  int bad   = 0;
  int acc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_lock = 0; m_gnt = 0; m_rr = 0; m_cnt = 0;
    m_ov = 0; m_od = '0; m_oc = '0;
  endtask

  // Nearest requester at or after start, going around the ring; -1 if none.
  function automatic int pick(input logic [N-1:0] req, input logic [1:0] start);
    logic [1:0] idx;
    for (int d = 0; d < N; d++) begin
      idx = 2'((int'(start) + d) % N);
      if (req[idx]) return int'(idx);
    end
    return -1;
  endfunction

  // One clock: entered at negedge with inputs already driven.
  task automatic cycle();
    int g;
    bit hold, xfer;
    logic [N-1:0] urg;
    logic [N-1:0] exp_drdy;
    #1;
    hold = m_lock && c_srdy[m_gnt];
    for (int n = 0; n < N; n++) urg[n] = c_srdy[n] && (32'(use_v[n]) >= HI);
    if (hold) g = int'(m_gnt);
    else if (pick(urg, m_rr) >= 0) g = pick(urg, m_rr);
    else g = pick(c_srdy, m_rr);
    xfer = !reset && clken && (g >= 0) && (!m_ov || p_drdy);
    exp_drdy = '0;
    if (xfer) exp_drdy[g] = 1'b1;
    check("c_drdy", 32'(c_drdy), 32'(exp_drdy));
    check("p_srdy", 32'(p_srdy), 32'(m_ov));
    check("p_data", 32'(p_data), 32'(m_od));
    check("p_chan", 32'(p_chan), 32'(m_oc));
    if (p_srdy && p_drdy && clken && !reset) acc_q.push_back(int'(p_chan));
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else if (clken) begin
      if (xfer) begin
        m_ov = 1; m_od = dat[g]; m_oc = 2'(g);
      end else if (p_drdy) begin
        m_ov = 0;
      end
      if (m_lock && !c_srdy[m_gnt]) begin
        m_lock = 0; m_rr = m_gnt + 2'd1;
      end
      if (xfer) begin
        if (hold) begin
          m_cnt++;
          if (m_cnt == MB) begin m_lock = 0; m_rr = m_gnt + 2'd1; end
        end else begin
          m_lock = 1; m_gnt = 2'(g); m_cnt = 1;
          if (MB == 1) begin m_lock = 0; m_rr = 2'(g) + 2'd1; end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      for (int k = 0; k < N; k++) dat[k] = W'($urandom);
      cycle();
    end
  endtask

  task automatic do_reset();
    reset = 1; model_reset();
    c_srdy = '0; p_drdy = 1; clken = 1;
    for (int k = 0; k < N; k++) use_v[k] = '0;
    run(2);
    reset = 0;
    acc_q.delete();
  endtask

  // exp holds channel i of the accepted sequence in nibble i.
  task automatic check_seq(input string name, input logic [63:0] exp, input int n);
    check({name, "_len"}, 32'(acc_q.size() >= n), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (i < acc_q.size()) check(name, 32'(acc_q[i]), 32'(exp[4*i +: 4]));
    end
  endtask

  initial begin
    reset = 1; clken = 1; p_drdy = 1; c_srdy = '0;
    for (int k = 0; k < N; k++) begin dat[k] = '0; use_v[k] = '0; end
    model_reset();
    @(negedge clk);

    // Reset state
    #1;
    check("rst_p_srdy", 32'(p_srdy), 32'd0);
    check("rst_p_data", 32'(p_data), 32'd0);
    check("rst_c_drdy", 32'(c_drdy), 32'd0);
    @(negedge clk);

    // Bursts of four rotating over all channels
    do_reset();
    c_srdy = 4'b1111;
    run(20);
    check_seq("rr_burst", 64'h3333_2222_1111_0000, 16);

    // Channel 2 becomes urgent mid-burst of channel 0
    do_reset();
    c_srdy = 4'b0111;
    run(2);
    use_v[2] = 5'd12;
    run(10);
    check_seq("urgent_pick", 64'h2_0000, 5);

    // Locked channel 1 drops srdy, channel 3 takes over in the same cycle
    do_reset();
    c_srdy = 4'b1010;
    run(2);
    c_srdy = 4'b1000;
    #1 check("drop_switch", 32'(c_drdy), 32'h8);
    run(6);
    check_seq("drop_seq", 64'h311, 3);

    // Output stall then clock-enable gap in the middle of a burst
    do_reset();
    c_srdy = 4'b1111;
    run(2);
    p_drdy = 0;
    run(5);
    p_drdy = 1;
    run(2);
    clken = 0;
    run(3);
    clken = 1;
    run(8);
    check_seq("stall_seq", 64'h22_1111_0000, 10);

    // Reset in the middle of a channel-2 burst
    do_reset();
    c_srdy = 4'b0100;
    run(3);
    reset = 1; model_reset();
    #1;
    check("midrst_p_srdy", 32'(p_srdy), 32'd0);
    check("midrst_c_drdy", 32'(c_drdy), 32'd0);
    cycle();
    reset = 0;
    c_srdy = 4'b1111;
    acc_q.delete();
    run(6);
    check_seq("post_reset", 64'h1_0000, 5);

    // Randomized traffic against the model
    do_reset();
    repeat (3000) begin
      c_srdy = N'($urandom);
      for (int k = 0; k < N; k++) use_v[k] = U'($urandom_range(0, 15));
      p_drdy = ($urandom % 4) != 0;
      clken  = ($urandom % 8) != 0;
      if (($urandom % 400) == 0) begin
        reset = 1; model_reset();
      end else begin
        reset = 0;
      end
      run(1);
    end
    reset = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
